dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 172 +++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and MMIO map for the data-memory responder.
// MMIO window is compiled in only when DMEM_MMIO_EN is defined.
package dmem_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF_S = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE_S = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] MMIO_BASE    = 32'hFFFF0000;
  localparam logic [1:0]  MMIO_LED     = 2'd0;
  localparam logic [1:0]  MMIO_SEG     = 2'd1;
  localparam logic [1:0]  MMIO_SCORE   = 2'd2;
  localparam logic [1:0]  MMIO_SCRATCH = 2'd3;

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:4] == MMIO_BASE[31:4];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// Purely combinational; shared by the store and load paths.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlane,
  output logic [31:0] o_ldata,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_off)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
  end

  always_comb begin
    o_be       = 4'b0000;
    o_wlane    = 32'h0;
    o_ldata    = 32'h0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_size)
      DM_WORD: begin
        o_be       = 4'b1111;
        o_wlane    = i_wdata;
        o_ldata    = i_rword;
        o_misalign = |i_off;
      end
      DM_HALF_S, DM_HALF_U: begin
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_wlane    = {2{i_wdata[15:0]}};
        o_misalign = i_off[0];
        if (i_size == DM_HALF_S)
          o_ldata = {{16{w_half[15]}}, w_half};
        else
          o_ldata = {16'h0, w_half};
      end
      DM_BYTE_S, DM_BYTE_U: begin
        o_be    = 4'b0001 << i_off;
        o_wlane = {4{i_wdata[7:0]}};
        if (i_size == DM_BYTE_S)
          o_ldata = {{24{w_byte[7]}}, w_byte};
        else
          o_ldata = {24'h0, w_byte};
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave with req/ready handshake and configurable wait states.
// Define DMEM_MMIO_EN to add the LED/SEG/SCORE/SCRATCH register window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dmem_control,
  input  logic        dmem_wena,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
`ifdef DMEM_MMIO_EN
  ,
  output logic [15:0] mmio_led,
  output logic [31:0] mmio_seg
`endif
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ctl;
  logic        r_wena;
  logic        r_ready;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_ldata;
  logic          w_misalign;
  logic          w_illegal;
  logic          w_inrange;
  logic          w_mmio_hit;
  logic          w_bad;
  logic          w_mem_we;

  assign w_off     = r_addr - BASE_ADDR;
  assign w_idx     = w_off[AW+1:2];
  assign w_rword   = r_mem[w_idx];
  assign w_inrange = w_off < LIMIT;

  dmem_lane_align u_align (
    .i_off      (w_off[1:0]),
    .i_size     (r_ctl),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wlane    (w_wlane),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] r_mmio [4];
  assign w_mmio_hit = is_mmio(r_addr);
  assign mmio_led   = r_mmio[MMIO_LED][15:0];
  assign mmio_seg   = r_mmio[MMIO_SEG];
`else
  assign w_mmio_hit = 1'b0;
`endif

  // MMIO window is decoded ahead of the RAM range check and is word-only
  assign w_bad = w_illegal | w_misalign |
                 (w_mmio_hit ? (r_ctl != DM_WORD) : !w_inrange);

  assign w_mem_we = (r_state == RESP) && r_wena && !w_bad &&
                    !w_mmio_hit && !reset;

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_ctl   <= 3'd0;
      r_wena  <= 1'b0;
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef DMEM_MMIO_EN
      for (int i = 0; i < 4; i++)
        r_mmio[i] <= 32'h0;
`endif
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          // the ready cycle still sees the old req held high
          if (req && !r_ready) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_ctl   <= dmem_control;
            r_wena  <= dmem_wena;
            r_busy  <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= 4'(WAIT_STATES);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1)
            r_state <= RESP;
        end
        RESP: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else begin
            r_err <= 1'b0;
`ifdef DMEM_MMIO_EN
            if (w_mmio_hit) begin
              if (r_wena)
                r_mmio[r_addr[3:2]] <= r_wdata;
              else
                r_rdata <= r_mmio[r_addr[3:2]];
            end else if (!r_wena) begin
              r_rdata <= w_ldata;
            end
`else
            if (!r_wena)
              r_rdata <= w_ldata;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_STATES=2.
// Covers lane steering, extension, error cases and mid-transaction reset.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h10010000;

  logic        clock;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dmem_control;
  logic        dmem_wena;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
`ifdef DMEM_MMIO_EN
  logic [15:0] mmio_led;
  logic [31:0] mmio_seg;
`endif

  int n_checks;
  int n_fail;

  dmem_responder #(
    .DEPTH_WORDS (2048),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .addr         (addr),
    .wdata        (wdata),
    .dmem_control (dmem_control),
    .dmem_wena    (dmem_wena),
    .ready        (ready),
    .rdata        (rdata),
    .err          (err),
    .busy         (busy)
`ifdef DMEM_MMIO_EN
    ,
    .mmio_led     (mmio_led),
    .mmio_seg     (mmio_seg)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c, input logic w,
                      output int lat, output logic e,
                      output logic [31:0] rd);
    @(negedge clock);
    req          = 1'b1;
    addr         = a;
    wdata        = d;
    dmem_control = c;
    dmem_wena    = w;
    @(posedge clock);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        lat = k;
        break;
      end
    end
    e  = err;
    rd = rdata;
    @(negedge clock);
    req = 1'b0;
  endtask

  int          lat;
  logic        e;
  logic [31:0] rd;
  logic        seen;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    req          = 1'b0;
    addr         = 32'h0;
    wdata        = 32'h0;
    dmem_control = 3'd0;
    dmem_wena    = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err",   {31'h0, err},   32'h0);
    chk("rst_busy",  {31'h0, busy},  32'h0);

    xact(BASE + 32'h4, 32'hDEADBEEF, 3'd0, 1'b1, lat, e, rd);
    chk("sw_lat",   lat, 32'd3);
    chk("sw_err",   {31'h0, e}, 32'h0);
    chk("sw_rdata", rd, 32'h0);
    xact(BASE + 32'h4, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("lw_lat",   lat, 32'd3);
    chk("lw_err",   {31'h0, e}, 32'h0);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    xact(BASE + 32'h8, 32'h80FF7F01, 3'd0, 1'b1, lat, e, rd);
    chk("sw2_keep", rd, 32'hDEADBEEF);
    xact(BASE + 32'hB, 32'h0, 3'd3, 1'b0, lat, e, rd);
    chk("lb",  rd, 32'hFFFFFF80);
    xact(BASE + 32'hB, 32'h0, 3'd4, 1'b0, lat, e, rd);
    chk("lbu", rd, 32'h00000080);
    xact(BASE + 32'h8, 32'h0, 3'd1, 1'b0, lat, e, rd);
    chk("lh",  rd, 32'h00007F01);
    xact(BASE + 32'hA, 32'h0, 3'd2, 1'b0, lat, e, rd);
    chk("lhu", rd, 32'h000080FF);
    xact(BASE + 32'hA, 32'h0, 3'd1, 1'b0, lat, e, rd);
    chk("lh_neg", rd, 32'hFFFF80FF);

    xact(BASE + 32'h10, 32'h11223344, 3'd0, 1'b1, lat, e, rd);
    xact(BASE + 32'h11, 32'h000000AA, 3'd4, 1'b1, lat, e, rd);
    chk("sb_err", {31'h0, e}, 32'h0);
    xact(BASE + 32'h10, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("sb_lw", rd, 32'h1122AA44);
    xact(BASE + 32'h12, 32'h0000BBCC, 3'd2, 1'b1, lat, e, rd);
    xact(BASE + 32'h10, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("sh_lw", rd, 32'hBBCCAA44);

    xact(BASE, 32'h0, 3'd0, 1'b1, lat, e, rd);
    xact(BASE + 32'h2, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("mis_lat",   lat, 32'd3);
    chk("mis_err",   {31'h0, e}, 32'h1);
    chk("mis_rdata", rd, 32'h0);
    xact(BASE + 32'h2, 32'h99999999, 3'd0, 1'b1, lat, e, rd);
    chk("mis_sw_err", {31'h0, e}, 32'h1);
    xact(BASE + 32'h2000, 32'h77777777, 3'd0, 1'b1, lat, e, rd);
    chk("oor_err", {31'h0, e}, 32'h1);
    xact(BASE, 32'h55555555, 3'd6, 1'b1, lat, e, rd);
    chk("ill_err", {31'h0, e}, 32'h1);
    xact(BASE, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("err_nowr_err", {31'h0, e}, 32'h0);
    chk("err_nowr",     rd, 32'h0);
    xact(BASE + 32'h4, 32'h0, 3'd0, 1'b0, lat, e, rd);
    xact(BASE + 32'h4, 32'h0, 3'd7, 1'b0, lat, e, rd);
    chk("ill_ld_err",   {31'h0, e}, 32'h1);
    chk("ill_ld_rdata", rd, 32'h0);

    @(negedge clock);
    req          = 1'b1;
    addr         = BASE;
    wdata        = 32'h12345678;
    dmem_control = 3'd0;
    dmem_wena    = 1'b1;
    @(posedge clock);
    #1;
    chk("busy_wait", {31'h0, busy}, 32'h1);
    @(negedge clock);
    reset = 1'b1;
    req   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (ready) seen = 1'b1;
    end
    chk("abort_ready", {31'h0, seen}, 32'h0);
    chk("abort_busy",  {31'h0, busy}, 32'h0);
    xact(BASE, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("abort_lat", lat, 32'd3);
    chk("abort_lw",  rd, 32'h0);

`ifdef DMEM_MMIO_EN
    chk("mmio_rst", {16'h0, mmio_led}, 32'h0);
    xact(32'hFFFF0000, 32'h0000BEEF, 3'd0, 1'b1, lat, e, rd);
    chk("mmio_sw_err", {31'h0, e}, 32'h0);
    chk("mmio_led",    {16'h0, mmio_led}, 32'h0000BEEF);
    xact(32'hFFFF0000, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("mmio_lw", rd, 32'h0000BEEF);
    xact(32'hFFFF0004, 32'hCAFEF00D, 3'd0, 1'b1, lat, e, rd);
    chk("mmio_seg", mmio_seg, 32'hCAFEF00D);
    xact(32'hFFFF0000, 32'h0, 3'd2, 1'b0, lat, e, rd);
    chk("mmio_sub_err", {31'h0, e}, 32'h1);
`else
    xact(32'hFFFF0000, 32'h0000BEEF, 3'd0, 1'b1, lat, e, rd);
    chk("mmio_off_err", {31'h0, e}, 32'h1);
    xact(32'hFFFF0000, 32'h0, 3'd0, 1'b0, lat, e, rd);
    chk("mmio_off_ld_err", {31'h0, e}, 32'h1);
    chk("mmio_off_rdata",  rd, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
